// File: rtl/pe_carry_resolver_pkg.sv
// Shared Montgomery datapath constants for the carry resolver.
package pe_carry_resolver_pkg;
  localparam int PE_K  = 16;
  localparam int PE_SW = 48;
  // Carry after a word nominally fits 2K bits; the rare extra top bit only appears on frame overflow.
  localparam int PE_FLUSH = (PE_SW - PE_K) / PE_K;

  typedef logic [PE_K-1:0] digit_t;
endpackage

// File: rtl/pe_carry_resolver.sv
// Normalises the redundant PE partial-sum stream into canonical K-bit digits,
// then flushes the residual carry as FLUSH extra digits per frame.
module pe_carry_resolver
  import pe_carry_resolver_pkg::*;
#(
  parameter int K     = PE_K,
  parameter int SW    = PE_SW,
  parameter int FLUSH = PE_FLUSH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SW-1:0]    in_s,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_digit,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);
  localparam int CW   = SW + 1 - K;
  localparam int AW   = SW + 1;
  localparam int FC_W = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t          state;
  logic [CW-1:0]   carry;
  logic [FC_W-1:0] fcnt;
  logic [AW-1:0]   acc;
  logic            adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = rst_n && adv && (state != S_FLUSH);
  assign busy     = (state != S_IDLE) || out_valid;
  // Carry is zero in IDLE (cleared by reset and by the final flush digit).
  assign acc      = {1'b0, in_s} + AW'(carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      carry     <= '0;
      fcnt      <= '0;
      out_valid <= 1'b0;
      out_digit <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (adv) begin
      case (state)
        S_IDLE, S_RUN: begin
          if (in_valid) begin
            out_valid <= 1'b1;
            out_digit <= acc[K-1:0];
            out_idx   <= (state == S_IDLE) ? '0 : out_idx + CNT_W'(1);
            out_last  <= 1'b0;
            carry     <= acc[SW:K];
            fcnt      <= '0;
            state     <= in_last ? S_FLUSH : S_RUN;
          end else begin
            out_valid <= 1'b0;
          end
        end
        S_FLUSH: begin
          out_valid <= 1'b1;
          out_digit <= carry[K-1:0];
          out_idx   <= out_idx + CNT_W'(1);
          fcnt      <= fcnt + 1'b1;
          if (fcnt == FC_W'(FLUSH - 1)) begin
            out_last <= 1'b1;
            carry    <= '0;
            state    <= S_IDLE;
          end else begin
            out_last <= 1'b0;
            carry    <= carry >> K;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_carry_resolver.sv
// Bench for pe_carry_resolver: vector table, hand sequences, random frames vs limb-sum model.
module tb_pe_carry_resolver;
  logic        clk = 0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [47:0] in_s;
  logic        out_valid, out_ready, out_last, busy;
  logic [15:0] out_digit;
  logic [7:0]  out_idx;

  int n_chk = 0, n_fail = 0;

  pe_carry_resolver dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_idx(out_idx), .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [47:0] w [4];
    logic [15:0] d [6];
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: the frame value is sum(w_j * 2^(16j)); digits are its base-2^16 expansion
  // truncated to n+2 digits (anything above the fixed frame length is dropped).
  function automatic void model(input int n, input logic [47:0] w [24], output logic [15:0] d [26]);
    longint lim [0:27];
    for (int i = 0; i < 28; i++) lim[i] = 0;
    for (int j = 0; j < n; j++) begin
      lim[j]   += longint'(w[j][15:0]);
      lim[j+1] += longint'(w[j][31:16]);
      lim[j+2] += longint'(w[j][47:32]);
    end
    for (int i = 0; i < 26; i++) begin
      lim[i+1] += lim[i] >> 16;
      d[i] = 16'(lim[i] & 64'hFFFF);
    end
  endfunction

  // mode 0: out_ready=1, 1: random, 2: repeating 1,0,0,1
  task automatic run_frame(input string nm, input int n, input logic [47:0] w [24],
                           input logic [15:0] exp [26], input int mode);
    int wi = 0, cyc = 0, pc = 0, ng = 0;
    bit perr = 0, derr = 0, stall = 0;
    logic [15:0] hd; logic [7:0] hi; logic hl;
    logic [15:0] got [26];
    while (ng < n + 2 && cyc < 2000) begin
      @(negedge clk);
      if (stall && (!out_valid || out_digit !== hd || out_idx !== hi || out_last !== hl)) perr = 1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (pc % 4 == 0) || (pc % 4 == 3);
      endcase
      pc++;
      in_valid = (wi < n);
      in_s     = (wi < n) ? w[wi] : 48'h0;
      in_last  = (wi == n - 1);
      #1;
      if (out_valid && !out_ready && in_ready) perr = 1;
      stall = out_valid && !out_ready;
      hd = out_digit; hi = out_idx; hl = out_last;
      if (out_valid && out_ready) begin
        if (out_idx !== 8'(ng) || out_last !== (ng == n + 1)) perr = 1;
        got[ng] = out_digit;
        ng++;
      end
      if (in_valid && in_ready) wi++;
      cyc++;
    end
    in_valid = 1'b0;
    if (ng < n + 2) perr = 1;
    for (int i = 0; i < ng && i < n + 2; i++) if (got[i] !== exp[i]) derr = 1;
    chk({nm, "_proto"}, {63'd0, perr}, 64'd0);
    chk({nm, "_digits"}, {63'd0, derr}, 64'd0);
  endtask

  initial begin
    vec_t tbl [3];
    logic [47:0] w [24];
    logic [15:0] e [26];

    tbl[0].n = 1; tbl[0].w = '{48'h0000_0001_2345, 0, 0, 0};
    tbl[0].d = '{16'h2345, 16'h0001, 16'h0000, 0, 0, 0};
    tbl[1].n = 2; tbl[1].w = '{48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 0, 0};
    tbl[1].d = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 0, 0};
    tbl[2].n = 3; tbl[2].w = '{48'h1234_5678_9ABC, 48'hFFFF_0000_0000, 48'h0000_0000_0002, 0};
    tbl[2].d = '{16'h9ABC, 16'h5678, 16'h1236, 16'hFFFF, 16'h0000, 0};

    rst_n = 0; in_valid = 0; in_s = 0; in_last = 0; out_ready = 1;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 0);
    chk("rst_out_digit", {48'd0, out_digit}, 0);
    chk("rst_out_idx",   {56'd0, out_idx}, 0);
    chk("rst_out_last",  {63'd0, out_last}, 0);
    chk("rst_busy",      {63'd0, busy}, 0);
    chk("rst_in_ready",  {63'd0, in_ready}, 0);
    @(negedge clk); rst_n = 1;

    // single-word latency
    @(negedge clk);
    in_valid = 1; in_s = 48'h0000_0001_2345; in_last = 1; out_ready = 1;
    #1 chk("lat_in_ready", {63'd0, in_ready}, 1);
    @(posedge clk); #1;
    chk("lat_out_valid", {63'd0, out_valid}, 1);
    chk("lat_digit0", {48'd0, out_digit}, 64'h2345);
    in_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("lat_last_idx", {56'd0, out_idx}, 2);
    chk("lat_last", {63'd0, out_last}, 1);
    @(posedge clk); #1;
    chk("lat_idle", {62'd0, busy, out_valid}, 0);

    // vector table
    foreach (tbl[t]) begin
      for (int i = 0; i < 24; i++) w[i] = (i < 4) ? tbl[t].w[i] : 48'h0;
      for (int i = 0; i < 26; i++) e[i] = (i < 6) ? tbl[t].d[i] : 16'h0;
      run_frame($sformatf("vec%0d", t), tbl[t].n, w, e, 0);
    end

    // backpressure 1,0,0,1 on a 4-word frame
    for (int i = 0; i < 24; i++) w[i] = (i < 4) ? {$urandom, $urandom} : 48'h0;
    model(4, w, e);
    run_frame("bp", 4, w, e, 2);

    // back-to-back: B offered while A's last digit is being consumed
    @(negedge clk);
    out_ready = 1; in_valid = 1; in_s = 48'hFFFF_FFFF_FFFF; in_last = 1;
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("b2b_a_last", {63'd0, out_last}, 1);
    in_valid = 1; in_s = 48'h7; in_last = 1;
    #1 chk("b2b_in_ready", {63'd0, in_ready}, 1);
    @(negedge clk); in_valid = 0;
    #1;
    chk("b2b_digit", {48'd0, out_digit}, 7);
    chk("b2b_idx", {56'd0, out_idx}, 0);
    chk("b2b_last", {63'd0, out_last}, 0);
    repeat (3) @(negedge clk);

    // reset after 2 of 4 words
    in_valid = 1; in_s = 48'hABCD_1234_5678; in_last = 0;
    @(negedge clk); in_s = 48'h1111_2222_3333;
    @(negedge clk); in_valid = 0;
    rst_n = 0;
    #1;
    chk("mrst_outs", {47'd0, out_valid, out_last, out_idx, busy, out_digit[5:0]}, 0);
    chk("mrst_digit", {48'd0, out_digit}, 0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 24; i++) w[i] = 48'h0;
    w[0] = 48'h7;
    for (int i = 0; i < 26; i++) e[i] = 16'h0;
    e[0] = 16'h7;
    run_frame("mrst_next", 1, w, e, 0);

    // random frames
    for (int f = 0; f < 1000; f++) begin
      int n = $urandom_range(1, 24);
      for (int i = 0; i < 24; i++) w[i] = (i < n) ? {$urandom, $urandom} : 48'h0;
      model(n, w, e);
      run_frame($sformatf("rnd%0d", f), n, w, e, 1);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
